output_port: RTL and testbench
==============================

OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries (power of two, 2..16); equals the upstream sender's initial credit count.
REQ-002 Parameter: ID, 0, port index; used only for identification.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 d_in  input  `PATH_WIDTH+1  fabric word from the FU/switch SE output; bit[0] valid, bit[1] meta/predicate, bits[`PATH_WIDTH:2] data.
REQ-006 c_out  output  1  credit return to the fabric; one-cycle pulse per freed entry.
REQ-007 out_data  output  `PATH_WIDTH-1  head-entry data, i.e. d_in[`PATH_WIDTH:2].
REQ-008 out_meta  output  1  head-entry meta bit.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  host accepts the head entry.
REQ-011 err_ovf  output  1  sticky overflow flag.
REQ-012 occupancy  output  clog2(DEPTH)+1  current entry count.

Function
REQ-013 Enqueue SHALL occur on any cycle with d_in[0]=1, regardless of out_ready.
REQ-014 Dequeue SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-015 Storage is a circular buffer: wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-016 Latency: an entry written at edge N SHALL appear at out_valid/out_data after edge N; no combinational path from d_in to outputs.
REQ-017 out_data/out_meta SHALL be driven from the rd_ptr entry and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 c_out SHALL be registered: high for exactly one cycle, the cycle after each dequeue; back-to-back dequeues SHALL give back-to-back pulses.
REQ-019 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-020 Full, no dequeue, d_in[0]=1: word dropped, occupancy unchanged, err_ovf set.
REQ-021 Empty with out_ready=1: no dequeue and no credit; pointers unchanged.
REQ-022 err_ovf SHALL stay set until rst.
REQ-023 occupancy SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-024 While rst=1 at a clock edge: pointers=0, occupancy=0, out_valid=0, c_out=0, err_ovf=0; out_data/out_meta=0.
REQ-025 Reset mid-operation SHALL discard all entries and any pending credit pulse; no credit SHALL be emitted for discarded entries (the fabric is reset together with this block).
REQ-026 d_in SHALL be ignored in any cycle with rst=1.

Configuration
REQ-027 Macro OUTPUT_PORT_STATS_EN: when defined, the block SHALL add output word_count (16 bits), which increments on each dequeue, wraps 0xFFFF->0, and clears on rst.
REQ-028 Without OUTPUT_PORT_STATS_EN, no word_count port and no counter logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-029 `PATH_WIDTH, `PATH_BITS and the meta-bit position SHALL come from the shared config include; no local redefinition.
REQ-030 Storage and pointers SHALL be in one sub-module, credit_fifo (write/read/full/empty/count); output_port adds the credit register, the overflow flag and the stats counter.

Verification
REQ-031 Reset, then d_in=data 0x5, meta=1, valid, for 1 cycle -> next cycle out_valid=1, out_data=0x5, out_meta=1, occupancy=1.
REQ-032 DEPTH=4, out_ready=0, 4 valid words 1..4 -> occupancy=4, err_ovf=0; 5th word -> dropped, err_ovf=1, head still 1.
REQ-033 Full FIFO, out_ready=1 and valid word 9 in the same cycle -> occupancy stays 4, c_out pulses next cycle, order afterwards 2,3,4,9.
REQ-034 4 entries, out_ready held 1 -> 4 consecutive c_out pulses, each one cycle after its dequeue, then out_valid=0.
REQ-035 3 entries, rst asserted for 1 cycle -> out_valid=0, occupancy=0, no c_out pulse afterwards, err_ovf cleared.
REQ-036 With OUTPUT_PORT_STATS_EN, word_count preset near wrap by 0x10000 dequeues -> word_count=0x0000; without the macro the port is absent.

Source files
------------

// File: rtl/output_port_pkg.sv
// Shared fabric word layout (PATH_WIDTH, PATH_BITS, meta position) and the FIFO entry type.
// These defines act as the fabric's shared configuration and are guarded so they are defined once.
`ifndef FABRIC_CFG_DEFINES
`define FABRIC_CFG_DEFINES
`define PATH_WIDTH 10
`define PATH_BITS (`PATH_WIDTH - 1)
`define PATH_META_BIT 1
`endif

package output_port_pkg;
    localparam int PATH_W   = `PATH_WIDTH;
    localparam int DATA_W   = `PATH_BITS;
    localparam int META_POS = `PATH_META_BIT;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              meta;
    } entry_t;

    // Split a fabric word into its stored fields; the valid bit is handled by the caller.
    function automatic entry_t fn_unpack(input logic [PATH_W:0] w);
        entry_t e;
        e.data = w[PATH_W:2];
        e.meta = w[META_POS];
        return e;
    endfunction
endpackage

// File: rtl/credit_fifo.sv
// Circular-buffer storage for output_port: pointers wrap DEPTH-1 -> 0, count tracks occupancy.
// Writes on a full buffer are accepted only when a read frees a slot in the same cycle.
module credit_fifo
    import output_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  entry_t                 i_wr_data,
    input  logic                   i_rd_en,
    output entry_t                 o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));
    assign w_rd    = i_rd_en && !w_empty;
    assign w_wr    = i_wr_en && (!w_full || w_rd);

    // Storage array; contents need no reset because the head is only visible via count.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? AW'(0) : r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? AW'(0) : r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
endmodule

// File: rtl/output_port.sv
// Fabric output port: credit FIFO plus registered credit return and sticky overflow flag.
// Optional OUTPUT_PORT_STATS_EN adds a 16-bit dequeued-word counter on port word_count.
module output_port
    import output_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`PATH_WIDTH:0]    d_in,
    output logic                    c_out,
    output logic [`PATH_WIDTH-2:0]  out_data,
    output logic                    out_meta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_ovf,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef OUTPUT_PORT_STATS_EN
    ,
    output logic [15:0]             word_count
`endif
);
    localparam int UNUSED_PORT_ID = ID;

    entry_t w_head;
    logic   w_full;
    logic   w_empty;
    logic   w_deq;
    logic   w_ovf;
    logic   r_c_out;
    logic   r_err_ovf;

    assign w_deq = !w_empty && out_ready;
    assign w_ovf = d_in[0] && w_full && !w_deq;

    credit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (d_in[0]),
        .i_wr_data (fn_unpack(d_in)),
        .i_rd_en   (out_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (occupancy)
    );

    // Credit pulse one cycle after each dequeue; overflow flag sticks until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_out   <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_c_out   <= w_deq;
            r_err_ovf <= r_err_ovf || w_ovf;
        end
    end

    // Head fields are forced to zero while the FIFO is empty.
    always_comb begin
        out_data = '0;
        out_meta = 1'b0;
        if (!w_empty) begin
            out_data = w_head.data;
            out_meta = w_head.meta;
        end else begin
            out_data = '0;
            out_meta = 1'b0;
        end
    end

`ifdef OUTPUT_PORT_STATS_EN
    logic [15:0] r_word_count;

    // Dequeued-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= 16'h0000;
        end else if (w_deq) begin
            r_word_count <= r_word_count + 16'h0001;
        end else begin
            r_word_count <= r_word_count;
        end
    end

    assign word_count = r_word_count;
`endif

    assign out_valid = !w_empty;
    assign c_out     = r_c_out;
    assign err_ovf   = r_err_ovf;
endmodule

// File: tb/tb_output_port.sv
// Bench for output_port: queue-based reference model checked every cycle plus directed literal checks.
module tb_output_port;
    import output_port_pkg::*;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [PATH_W:0]   d_in;
    logic              c_out;
    logic [DATA_W-1:0] out_data;
    logic              out_meta;
    logic              out_valid;
    logic              out_ready;
    logic              err_ovf;
    logic [OW-1:0]     occupancy;
`ifdef OUTPUT_PORT_STATS_EN
    logic [15:0]       word_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    output_port #(.DEPTH(DEPTH), .ID(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .c_out     (c_out),
        .out_data  (out_data),
        .out_meta  (out_meta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_ovf   (err_ovf),
        .occupancy (occupancy)
`ifdef OUTPUT_PORT_STATS_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ideal bounded queue updated at each rising edge.
    entry_t      mq[$];
    logic        m_cout  = 1'b0;
    logic        m_err   = 1'b0;
    logic [15:0] m_wc    = 16'h0000;
    bit          started = 1'b0;

    initial begin
        forever begin
            bit full;
            bit deq;
            entry_t e;
            @(posedge clk);
            started = 1'b1;
            if (rst) begin
                mq.delete();
                m_cout = 1'b0;
                m_err  = 1'b0;
                m_wc   = 16'h0000;
            end else begin
                full   = (mq.size() == DEPTH);
                deq    = (mq.size() > 0) && out_ready;
                m_cout = deq;
                if (deq) begin
                    void'(mq.pop_front());
                    m_wc = m_wc + 16'h0001;
                end
                if (d_in[0]) begin
                    e.data = d_in[PATH_W:2];
                    e.meta = d_in[1];
                    if (!full || deq) mq.push_back(e);
                    else m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("m_valid", 32'(out_valid), 32'(mq.size() > 0));
                check("m_occ", 32'(occupancy), 32'(mq.size()));
                check("m_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0].data) : 32'h0);
                check("m_meta", 32'(out_meta), (mq.size() > 0) ? 32'(mq[0].meta) : 32'h0);
                check("m_cout", 32'(c_out), 32'(m_cout));
                check("m_err", 32'(err_ovf), 32'(m_err));
`ifdef OUTPUT_PORT_STATS_EN
                check("m_wc", 32'(word_count), 32'(m_wc));
`endif
            end
        end
    end

    // Apply one cycle of inputs, then return at the following falling edge.
    task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                         input logic m, input logic rdy);
        rst       = r;
        d_in      = {d, m, v};
        out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; d_in = '0; out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b1, 9'h1AA, 1'b1, 1'b0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_cout", 32'(c_out), 32'h0);
        check("rst_err", 32'(err_ovf), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);

        drive(1'b0, 1'b1, 9'h005, 1'b1, 1'b0);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_data", 32'(out_data), 32'h5);
        check("single_meta", 32'(out_meta), 32'h1);
        check("single_occ", 32'(occupancy), 32'h1);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("single_cout", 32'(c_out), 32'h1);
        check("single_empty", 32'(occupancy), 32'h0);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("empty_no_credit", 32'(c_out), 32'h0);

        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 9'(i), 1'b0, 1'b0);
        check("fill_occ", 32'(occupancy), 32'h4);
        check("fill_err", 32'(err_ovf), 32'h0);
        drive(1'b0, 1'b1, 9'h005, 1'b0, 1'b0);
        check("ovf_occ", 32'(occupancy), 32'h4);
        check("ovf_err", 32'(err_ovf), 32'h1);
        check("ovf_head", 32'(out_data), 32'h1);

        drive(1'b0, 1'b1, 9'h009, 1'b0, 1'b1);
        check("full_rw_occ", 32'(occupancy), 32'h4);
        check("full_rw_cout", 32'(c_out), 32'h1);
        begin
            logic [31:0] exp_order [4] = '{32'h2, 32'h3, 32'h4, 32'h9};
            for (int i = 0; i < 4; i++) begin
                check("order", 32'(out_data), exp_order[i]);
                drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
                check("drain_cout", 32'(c_out), 32'h1);
            end
        end
        check("drain_valid", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("drain_cout_end", 32'(c_out), 32'h0);
        check("err_sticky", 32'(err_ovf), 32'h1);

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 9'(16 + i), 1'b1, 1'b0);
        check("pre_rst_occ", 32'(occupancy), 32'h3);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 9'h0EE, 1'b1, 1'b1);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_occ", 32'(occupancy), 32'h0);
        check("mid_rst_cout", 32'(c_out), 32'h0);
        check("mid_rst_err", 32'(err_ovf), 32'h0);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("post_rst_cout", 32'(c_out), 32'h0);

`ifdef OUTPUT_PORT_STATS_EN
        drive(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) drive(1'b0, 1'b1, 9'(i), 1'b0, 1'b1);
        check("wc_near_wrap", 32'(word_count), 32'hFFFF);
        drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("wc_wrap", 32'(word_count), 32'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
